register_file_wb: RTL and testbench
===================================

REGISTER_FILE_WB -- requirements
Module: register_file_wb

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports are named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 RegWriteW  input  1  writeback write enable.
REQ-005 RD_W  input  5  writeback destination register index.
REQ-006 ResultW  input  32  writeback data.
REQ-007 A1  input  5  read port 1 address (rs1).
REQ-008 A2  input  5  read port 2 address (rs2).
REQ-009 RD1  output  32  read port 1 data.
REQ-010 RD2  output  32  read port 2 data.
REQ-011 IssueEn  input  1  decode issues an instruction that will write a register.
REQ-012 IssueRd  input  5  destination index of the issued instruction.
REQ-013 Busy1  output  1  rs1 has an outstanding, not-yet-written result.
REQ-014 Busy2  output  1  rs2 has an outstanding, not-yet-written result.

Function
REQ-015 Storage SHALL be 31 x 32-bit registers for x1..x31; x0 SHALL always read 0 and SHALL never be written or marked busy.
REQ-016 Writes SHALL occur on the rising clk edge when RegWriteW=1 and RD_W!=0, with rst=0.
REQ-017 RD1 and RD2 SHALL be combinational reads: zero latency from A1/A2 change.
REQ-018 Write-through bypass: when RegWriteW=1, RD_W!=0, and RD_W equals A1 (or A2), RD1 (or RD2) SHALL return ResultW in the same cycle, not the stored value.
REQ-019 Scoreboard: a 32-bit busy vector; bit 0 SHALL be constant 0.
REQ-020 On a clk edge with IssueEn=1 and IssueRd!=0, busy[IssueRd] SHALL be set to 1.
REQ-021 On a clk edge with RegWriteW=1 and RD_W!=0, busy[RD_W] SHALL be cleared to 0.
REQ-022 Simultaneous set and clear of the same index SHALL leave the bit set (the new issue wins).
REQ-023 Simultaneous set and clear of different indices SHALL both take effect.
REQ-024 Busy1 = busy[A1] & ~(RegWriteW & RD_W==A1 & RD_W!=0); Busy2 is defined the same way for A2. A register written this cycle therefore reads as not busy, because its data is available through the bypass.
REQ-025 A1==A2 SHALL return identical data and busy values on both ports.
REQ-026 A write to a register that is not busy SHALL still update storage, and its busy bit SHALL remain 0.

Reset
REQ-027 With rst=1 at a clk edge, all registers x1..x31 SHALL become 0 and all busy bits SHALL become 0; writes and issues in that cycle SHALL be ignored.
REQ-028 After reset, RD1=RD2=0 and Busy1=Busy2=0 for every address until the first write or issue.
REQ-029 Reset asserted mid-operation (busy bits set, writes pending) SHALL discard all state in one cycle, with no partial update.

Verification
REQ-030 Reset then read all 32 addresses -> RD1=RD2=0x00000000 and Busy1=Busy2=0 for every address.
REQ-031 Write RD_W=5, ResultW=0xDEADBEEF; next cycle A1=5 -> RD1=0xDEADBEEF. Write RD_W=0, ResultW=0x12345678; A2=0 -> RD2=0.
REQ-032 Bypass: with x7=0x11 stored, in one cycle RegWriteW=1, RD_W=7, ResultW=0x22, A1=A2=7 -> RD1=RD2=0x22 in that same cycle; next cycle with RegWriteW=0 -> still 0x22.
REQ-033 Scoreboard: IssueEn=1, IssueRd=9 -> next cycle A1=9 gives Busy1=1. Writeback with RD_W=9 -> Busy1=0 in the writeback cycle itself (REQ-024). The following cycle also shows Busy1=0.
REQ-034 Same-cycle collision: busy[4]=1, then IssueEn=1, IssueRd=4 together with RegWriteW=1, RD_W=4, ResultW=0xA5 -> next cycle RD1(A1=4)=0xA5 and Busy1=1. IssueRd=0 -> Busy never asserts for x0.
REQ-035 Mid-operation reset: x3=0x55, busy[3]=1, rst=1 in the same cycle as a write of 0x66 to x3 -> next cycle x3 reads 0 and Busy for x3 is 0.

Source files
------------

// File: rtl/register_file_wb_if.sv
// Register file bus: writeback port, two read ports and the issue/scoreboard port.
interface register_file_wb_if;
   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;

   logic            RegWriteW;
   logic [AW-1:0]   RD_W;
   logic [XLEN-1:0] ResultW;
   logic [AW-1:0]   A1;
   logic [AW-1:0]   A2;
   logic [XLEN-1:0] RD1;
   logic [XLEN-1:0] RD2;
   logic            IssueEn;
   logic [AW-1:0]   IssueRd;
   logic            Busy1;
   logic            Busy2;

   // Pipeline side: drives writeback, read addresses and issue.
   modport master (
      output RegWriteW, RD_W, ResultW, A1, A2, IssueEn, IssueRd,
      input  RD1, RD2, Busy1, Busy2
   );

   // Register file side.
   modport slave (
      input  RegWriteW, RD_W, ResultW, A1, A2, IssueEn, IssueRd,
      output RD1, RD2, Busy1, Busy2
   );
endinterface

// File: rtl/register_file_wb.sv
// 31 x 32-bit register file (x0 hardwired to zero) with write-through bypass
// and a busy scoreboard that tracks issued-but-not-written destinations.
module register_file_wb (
   input logic                clk,
   input logic                rst,
   register_file_wb_if.slave  bus
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;

   logic [XLEN-1:0] regs [1:NREG-1];
   // Busy bit 0 is implicitly constant 0 and therefore not stored.
   logic [NREG-1:1] busy;
   logic [NREG-1:1] busy_next;
   logic            wr_en;
   logic            iss_en;
   logic            hit1;
   logic            hit2;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic            busy1;
   logic            busy2;

   assign wr_en  = bus.RegWriteW && (bus.RD_W != '0);
   assign iss_en = bus.IssueEn && (bus.IssueRd != '0);
   assign hit1   = wr_en && (bus.RD_W == bus.A1);
   assign hit2   = wr_en && (bus.RD_W == bus.A2);

   // Scoreboard update: clear on writeback first, so a same-index issue wins.
   always_comb begin
      busy_next = busy;
      if (wr_en)
         busy_next[bus.RD_W] = 1'b0;
      if (iss_en)
         busy_next[bus.IssueRd] = 1'b1;
   end

   // Storage and scoreboard state; reset discards everything in one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 1; i < NREG; i++)
            regs[i] <= '0;
         busy <= '0;
      end else begin
         if (wr_en)
            regs[bus.RD_W] <= bus.ResultW;
         busy <= busy_next;
      end
   end

   // Combinational reads with bypass of the in-flight writeback value.
   always_comb begin
      rd1   = '0;
      rd2   = '0;
      busy1 = 1'b0;
      busy2 = 1'b0;
      if (bus.A1 != '0) begin
         rd1   = hit1 ? bus.ResultW : regs[bus.A1];
         busy1 = busy[bus.A1] && !hit1;
      end
      if (bus.A2 != '0) begin
         rd2   = hit2 ? bus.ResultW : regs[bus.A2];
         busy2 = busy[bus.A2] && !hit2;
      end
   end

   assign bus.RD1   = rd1;
   assign bus.RD2   = rd2;
   assign bus.Busy1 = busy1;
   assign bus.Busy2 = busy2;
endmodule

// File: tb/tb_register_file_wb.sv
// Self-checking bench for register_file_wb: directed scenarios plus a
// randomized run against an array-based reference model.
module tb_register_file_wb;
   logic clk = 1'b0;
   logic rst;
   int   vectors    = 0;
   int   miscompares = 0;

   logic [31:0] mregs [32];
   bit          mbusy [32];

   register_file_wb_if ifc ();

   register_file_wb dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   always #5 clk = ~clk;

   // Apply one set of inputs; outputs are checked 1ns later.
   task automatic drive(input bit we, input bit [4:0] rd, input bit [31:0] res,
                        input bit [4:0] a1, input bit [4:0] a2,
                        input bit iss, input bit [4:0] ird, input bit r);
      ifc.RegWriteW = we;
      ifc.RD_W      = rd;
      ifc.ResultW   = res;
      ifc.A1        = a1;
      ifc.A2        = a2;
      ifc.IssueEn   = iss;
      ifc.IssueRd   = ird;
      rst           = r;
      #1;
   endtask

   // Advance one clock edge and apply the architectural rules to the model.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            mregs[i] = '0;
            mbusy[i] = 1'b0;
         end
      end else begin
         if (ifc.RegWriteW && ifc.RD_W != 0) begin
            mregs[ifc.RD_W] = ifc.ResultW;
            mbusy[ifc.RD_W] = 1'b0;
         end
         if (ifc.IssueEn && ifc.IssueRd != 0)
            mbusy[ifc.IssueRd] = 1'b1;
      end
      #1;
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (ifc.RegWriteW && ifc.RD_W == a) return ifc.ResultW;
      return mregs[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (a == 0) return 1'b0;
      return mbusy[a] && !(ifc.RegWriteW && ifc.RD_W == a);
   endfunction

   task automatic test_reset();
      drive(1, 5'd3, 32'hFFFF_0000, 0, 0, 1, 5'd3, 1);
      tick();
      for (int a = 0; a < 32; a++) begin
         drive(0, 0, 0, 5'(a), 5'(31 - a), 0, 0, 0);
         vectors++;
         if (ifc.RD1 !== 32'h0 || ifc.RD2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rd a=%0d rd1=%h rd2=%h required 0", a, ifc.RD1, ifc.RD2);
         end
         vectors++;
         if (ifc.Busy1 !== 1'b0 || ifc.Busy2 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy a=%0d busy1=%b busy2=%b required 0", a, ifc.Busy1, ifc.Busy2);
         end
         tick();
      end
   endtask

   task automatic test_write_read();
      drive(1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 5'd5, 0, 0, 0, 0);
      vectors++;
      if (ifc.RD1 !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL write_read rd1=%h required deadbeef", ifc.RD1);
      end
      drive(1, 5'd0, 32'h1234_5678, 0, 0, 0, 0, 0);
      vectors++;
      if (ifc.RD2 !== 32'h0) begin
         miscompares++;
         $display("FAIL x0_bypass rd2=%h required 0", ifc.RD2);
      end
      tick();
      drive(0, 0, 0, 5'd5, 0, 0, 0, 0);
      vectors++;
      if (ifc.RD2 !== 32'h0 || ifc.RD1 !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL x0_write rd1=%h rd2=%h required deadbeef/0", ifc.RD1, ifc.RD2);
      end
   endtask

   task automatic test_bypass();
      drive(1, 5'd7, 32'h11, 0, 0, 0, 0, 0);
      tick();
      drive(1, 5'd7, 32'h22, 5'd7, 5'd7, 0, 0, 0);
      vectors++;
      if (ifc.RD1 !== 32'h22 || ifc.RD2 !== 32'h22) begin
         miscompares++;
         $display("FAIL bypass_same rd1=%h rd2=%h required 22", ifc.RD1, ifc.RD2);
      end
      tick();
      drive(0, 0, 0, 5'd7, 5'd7, 0, 0, 0);
      vectors++;
      if (ifc.RD1 !== 32'h22 || ifc.RD2 !== 32'h22) begin
         miscompares++;
         $display("FAIL bypass_next rd1=%h rd2=%h required 22", ifc.RD1, ifc.RD2);
      end
   endtask

   task automatic test_scoreboard();
      drive(0, 0, 0, 0, 0, 1, 5'd9, 0);
      tick();
      drive(0, 0, 0, 5'd9, 0, 0, 0, 0);
      vectors++;
      if (ifc.Busy1 !== 1'b1) begin
         miscompares++;
         $display("FAIL sb_set busy1=%b required 1", ifc.Busy1);
      end
      drive(1, 5'd9, 32'h0BAD_F00D, 5'd9, 0, 0, 0, 0);
      vectors++;
      if (ifc.Busy1 !== 1'b0 || ifc.RD1 !== 32'h0BAD_F00D) begin
         miscompares++;
         $display("FAIL sb_wb_cycle busy1=%b rd1=%h required 0/0badf00d", ifc.Busy1, ifc.RD1);
      end
      tick();
      drive(0, 0, 0, 5'd9, 0, 0, 0, 0);
      vectors++;
      if (ifc.Busy1 !== 1'b0) begin
         miscompares++;
         $display("FAIL sb_cleared busy1=%b required 0", ifc.Busy1);
      end
   endtask

   task automatic test_collision();
      drive(0, 0, 0, 0, 0, 1, 5'd4, 0);
      tick();
      drive(1, 5'd4, 32'hA5, 0, 0, 1, 5'd4, 0);
      tick();
      drive(0, 0, 0, 5'd4, 0, 0, 0, 0);
      vectors++;
      if (ifc.RD1 !== 32'hA5 || ifc.Busy1 !== 1'b1) begin
         miscompares++;
         $display("FAIL collide_same rd1=%h busy1=%b required a5/1", ifc.RD1, ifc.Busy1);
      end
      drive(1, 5'd4, 32'h5A, 0, 0, 1, 5'd10, 0);
      tick();
      drive(0, 0, 0, 5'd4, 5'd10, 0, 0, 0);
      vectors++;
      if (ifc.Busy1 !== 1'b0 || ifc.Busy2 !== 1'b1 || ifc.RD1 !== 32'h5A) begin
         miscompares++;
         $display("FAIL collide_diff busy4=%b busy10=%b rd1=%h required 0/1/5a",
                  ifc.Busy1, ifc.Busy2, ifc.RD1);
      end
      drive(0, 0, 0, 0, 0, 1, 5'd0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (ifc.Busy1 !== 1'b0 || ifc.Busy2 !== 1'b0) begin
         miscompares++;
         $display("FAIL x0_busy busy1=%b busy2=%b required 0", ifc.Busy1, ifc.Busy2);
      end
   endtask

   task automatic test_mid_reset();
      drive(1, 5'd3, 32'h55, 0, 0, 1, 5'd3, 0);
      tick();
      drive(1, 5'd3, 32'h66, 0, 0, 1, 5'd12, 1);
      tick();
      drive(0, 0, 0, 5'd3, 5'd12, 0, 0, 0);
      vectors++;
      if (ifc.RD1 !== 32'h0 || ifc.Busy1 !== 1'b0 || ifc.Busy2 !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset rd1=%h busy3=%b busy12=%b required 0/0/0",
                  ifc.RD1, ifc.Busy1, ifc.Busy2);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         bit [4:0] a1, a2, rd, ird;
         bit       narrow;
         narrow = ($urandom_range(0, 1) == 1);
         a1  = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
         a2  = ($urandom_range(0, 7) == 0) ? a1 : (narrow ? 5'($urandom_range(0, 7)) : 5'($urandom));
         rd  = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
         ird = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
         drive(1'($urandom), rd, $urandom, a1, a2, 1'($urandom_range(0, 2) == 0), ird,
               $urandom_range(0, 60) == 0);
         vectors++;
         if (ifc.RD1 !== exp_rd(a1) || ifc.RD2 !== exp_rd(a2)) begin
            miscompares++;
            $display("FAIL rand_rd n=%0d a1=%0d a2=%0d rd1=%h rd2=%h required %h/%h",
                     n, a1, a2, ifc.RD1, ifc.RD2, exp_rd(a1), exp_rd(a2));
         end
         vectors++;
         if (ifc.Busy1 !== exp_busy(a1) || ifc.Busy2 !== exp_busy(a2)) begin
            miscompares++;
            $display("FAIL rand_busy n=%0d a1=%0d a2=%0d busy1=%b busy2=%b required %b/%b",
                     n, a1, a2, ifc.Busy1, ifc.Busy2, exp_busy(a1), exp_busy(a2));
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      for (int r = 1; r < 32; r++) begin
         drive(1, 5'(r), 32'(r * 32'h0101_0101), 5'(r - 1), 5'(r), 1, 5'(r), 0);
         tick();
      end
      for (int r = 1; r < 32; r++) begin
         drive(0, 0, 0, 5'(r), 5'(r), 0, 0, 0);
         vectors++;
         if (ifc.RD1 !== 32'(r * 32'h0101_0101) || ifc.Busy1 !== 1'b1 || ifc.RD2 !== ifc.RD1) begin
            miscompares++;
            $display("FAIL b2b r=%0d rd1=%h busy1=%b rd2=%h required %h/1/same",
                     r, ifc.RD1, ifc.Busy1, ifc.RD2, 32'(r * 32'h0101_0101));
         end
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         mregs[i] = '0;
         mbusy[i] = 1'b0;
      end
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      test_reset();
      test_write_read();
      test_bypass();
      test_scoreboard();
      test_collision();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
